hawk_ctrl_arb_unit: RTL

Parametrised next-generation Hawk control unit. It arbitrates NUM_CH CPU request channels round-robin, with zero-block-write hint per channel, plus the Hawk command path. It issues one ATT lookup at a time to the page read manager, retries on denial or timeout, and returns the translated PPN to the granted channel. It also sequences ATT/free-list initialisation after reset. It sits between the CPU interface and hawk_pg_rdmanager/hawk_pg_writer.

---
 rtl/hawk_ctrl_arb_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/hawk_ctrl_arb_unit.sv
// Hawk control unit: init sequencing, round-robin CPU channel arbitration with
// Hawk command starvation guard, single outstanding ATT lookup with retry.
module hawk_ctrl_arb_unit #(
   parameter int NUM_CH         = 2,
   parameter int ADDR_W         = 40,
   parameter int LKUP_TIMEOUT   = 1024,
   parameter int CMD_STARVE_MAX = 4,
   localparam int CH_W          = (NUM_CH > 2) ? $clog2(NUM_CH) : 1,
   localparam int PPN_W         = ADDR_W - 12
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    init_att_done,
   input  logic                    init_list_done,
   output logic                    init_att,
   output logic                    init_list,
   input  logic [NUM_CH-1:0]       req_valid_i,
   input  logic [NUM_CH*PPN_W-1:0] req_hppa_i,
   input  logic [NUM_CH-1:0]       req_zero_i,
   input  logic                    pgrd_mngr_ready,
   output logic                    lkup_valid_o,
   output logic [PPN_W-1:0]        lkup_hppa_o,
   output logic                    lkup_zero_o,
   output logic [CH_W-1:0]         lkup_ch_o,
   input  logic                    trnsl_valid_i,
   input  logic                    trnsl_allow_i,
   input  logic [PPN_W-1:0]        trnsl_ppa_i,
   output logic [NUM_CH-1:0]       grant_valid_o,
   output logic [PPN_W-1:0]        grant_ppa_o,
   output logic                    lkup_timeout_o,
   input  logic                    hawk_cmd_ready,
   output logic                    hawk_cmd_run,
   output logic [3:0]              cu_state
);

   localparam int TO_W = $clog2(LKUP_TIMEOUT);
   localparam int SC_W = $clog2(CMD_STARVE_MAX + 1);

   typedef enum logic [3:0] {
      ST_INIT     = 4'd0,
      ST_ARB      = 4'd1,
      ST_LKP_REQ  = 4'd2,
      ST_LKP_WAIT = 4'd3,
      ST_GRANT    = 4'd4,
      ST_HAWK_CMD = 4'd5
   } state_t;

   state_t            state_reg;
   logic [CH_W-1:0]   rr_ptr_reg;
   logic [SC_W-1:0]   starve_cnt_reg;
   logic [TO_W-1:0]   to_cnt_reg;

   logic [PPN_W-1:0]  hppa_arr [NUM_CH];
   logic [CH_W-1:0]   sel_ch;
   logic              sel_found;
   logic              cmd_take;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_hppa
         assign hppa_arr[gi] = req_hppa_i[gi*PPN_W +: PPN_W];
      end
   endgenerate

   // Scan downward in priority so the lowest offset from rr_ptr wins last.
   always_comb begin
      int idx;
      idx       = 0;
      sel_ch    = '0;
      sel_found = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx = int'(rr_ptr_reg) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (req_valid_i[idx]) begin
            sel_ch    = CH_W'(idx);
            sel_found = 1'b1;
         end
      end
   end

   assign cmd_take = hawk_cmd_ready &&
                     (!(|req_valid_i) || (starve_cnt_reg == SC_W'(CMD_STARVE_MAX)));

   assign cu_state = state_reg;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg      <= ST_INIT;
         rr_ptr_reg     <= '0;
         starve_cnt_reg <= '0;
         to_cnt_reg     <= '0;
         init_att       <= 1'b1;
         init_list      <= 1'b1;
         lkup_valid_o   <= 1'b0;
         lkup_hppa_o    <= '0;
         lkup_zero_o    <= 1'b0;
         lkup_ch_o      <= '0;
         grant_valid_o  <= '0;
         grant_ppa_o    <= '0;
         lkup_timeout_o <= 1'b0;
         hawk_cmd_run   <= 1'b0;
      end else begin
         lkup_valid_o   <= 1'b0;
         lkup_timeout_o <= 1'b0;
         grant_valid_o  <= '0;
         case (state_reg)
            ST_INIT: begin
               if (init_att_done)  init_att  <= 1'b0;
               if (init_list_done) init_list <= 1'b0;
               if (!init_att && !init_list) state_reg <= ST_ARB;
            end
            ST_ARB: begin
               if (cmd_take) begin
                  hawk_cmd_run   <= 1'b1;
                  starve_cnt_reg <= '0;
                  state_reg      <= ST_HAWK_CMD;
               end else if (sel_found) begin
                  lkup_hppa_o <= hppa_arr[sel_ch];
                  lkup_zero_o <= req_zero_i[sel_ch];
                  lkup_ch_o   <= sel_ch;
                  state_reg   <= ST_LKP_REQ;
               end
            end
            ST_LKP_REQ: begin
               if (pgrd_mngr_ready) begin
                  lkup_valid_o <= 1'b1;
                  to_cnt_reg   <= '0;
                  state_reg    <= ST_LKP_WAIT;
               end
            end
            ST_LKP_WAIT: begin
               // A response in the final counter cycle takes precedence over the timeout.
               if (trnsl_valid_i && trnsl_allow_i) begin
                  grant_ppa_o   <= trnsl_ppa_i;
                  grant_valid_o <= NUM_CH'(1) << lkup_ch_o;
                  state_reg     <= ST_GRANT;
               end else if (trnsl_valid_i) begin
                  state_reg <= ST_LKP_REQ;
               end else if (to_cnt_reg == TO_W'(LKUP_TIMEOUT - 1)) begin
                  lkup_timeout_o <= 1'b1;
                  state_reg      <= ST_LKP_REQ;
               end else begin
                  to_cnt_reg <= to_cnt_reg + 1'b1;
               end
            end
            ST_GRANT: begin
               rr_ptr_reg <= (lkup_ch_o == CH_W'(NUM_CH - 1)) ? '0 : lkup_ch_o + 1'b1;
               if (hawk_cmd_ready) begin
                  if (starve_cnt_reg != SC_W'(CMD_STARVE_MAX))
                     starve_cnt_reg <= starve_cnt_reg + 1'b1;
               end else begin
                  starve_cnt_reg <= '0;
               end
               state_reg <= ST_ARB;
            end
            ST_HAWK_CMD: begin
               if (!hawk_cmd_ready) begin
                  hawk_cmd_run <= 1'b0;
                  state_reg    <= ST_ARB;
               end
            end
            default: state_reg <= ST_ARB;
         endcase
      end
   end

endmodule
